// File: rtl/interval_timer_ctrl_pkg.sv
// Shared types and defaults for the interval timer controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package timer_pkg;

  localparam int DEF_W     = 8;
  localparam int DEF_PRE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/interval_timer_ctrl_if.sv
// Config handshake, run control and status bundle for the interval timer.
// Latency: n/a (wiring only).
// Backpressure: cfg_ready low while the timer runs; optional macro INTERVAL_PRESCALE_EN adds cfg_prescale.
interface interval_timer_ctrl_if #(
  parameter int W = timer_pkg::DEF_W
`ifdef INTERVAL_PRESCALE_EN
  , parameter int PRE_W = timer_pkg::DEF_PRE_W
`endif
);

  logic             cfg_valid;
  logic             cfg_ready;
  logic [W-1:0]     cfg_limit;
  logic             cfg_periodic;
`ifdef INTERVAL_PRESCALE_EN
  logic [PRE_W-1:0] cfg_prescale;
`endif
  logic             start;
  logic             stop;
  logic             busy;
  logic [W-1:0]     count;
  logic             tick;
  logic             done;

  // Control/register side: offers config and start/stop, observes status.
  modport master (
    output cfg_valid, cfg_limit, cfg_periodic,
`ifdef INTERVAL_PRESCALE_EN
    output cfg_prescale,
`endif
    output start, stop,
    input  cfg_ready, busy, count, tick, done
  );

  // Timer side.
  modport slave (
    input  cfg_valid, cfg_limit, cfg_periodic,
`ifdef INTERVAL_PRESCALE_EN
    input  cfg_prescale,
`endif
    input  start, stop,
    output cfg_ready, busy, count, tick, done
  );

endinterface

// File: rtl/interval_timer_ctrl_counter.sv
// Synchronous W-bit up-counter with clear priority over enable.
// Latency: count updates one cycle after clr/en are sampled.
// Backpressure: none; holds its value whenever en is low.
module sync_counter_core import timer_pkg::*; #(
  parameter int W = DEF_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clr,
  input  logic         i_en,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  // Clear wins over increment so a start or reload always lands on zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/interval_timer_ctrl.sv
// Programmable interval timer: config handshake, IDLE/RUN/DONE sequencing, terminal tick.
// Latency: count=k after k enabled edges from start; tick/done one edge after count==limit.
// Backpressure: cfg_ready low in RUN; optional macro INTERVAL_PRESCALE_EN divides the count enable.
module interval_timer_ctrl import timer_pkg::*; #(
  parameter int W = DEF_W
`ifdef INTERVAL_PRESCALE_EN
  , parameter int PRE_W = DEF_PRE_W
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  interval_timer_ctrl_if.slave  io_bus
);

  state_t       r_state;
  state_t       w_state_nxt;
  logic [W-1:0] r_limit;
  logic         r_periodic;
  logic         r_tick;
  logic         r_done;

  logic         w_acc;
  logic [W-1:0] w_eff_limit;
  logic         w_start;
  logic         w_en;
  logic         w_term;
  logic         w_clr;
  logic         w_cnt_en;
  logic         w_tick_nxt;
  logic         w_done_nxt;
  logic [W-1:0] w_cnt;

  // A config is only taken outside RUN; a start on the same edge uses the new limit.
  assign w_acc       = io_bus.cfg_valid && (r_state != RUN);
  assign w_eff_limit = w_acc ? io_bus.cfg_limit : r_limit;
  assign w_start     = io_bus.start && (r_state != RUN) && (w_eff_limit != '0);
  assign w_term      = (r_state == RUN) && w_en && (w_cnt == r_limit);

`ifdef INTERVAL_PRESCALE_EN
  logic [PRE_W-1:0] r_pre_q;
  logic [PRE_W-1:0] r_pre_cnt;

  // Prescaler: restarts on start, strobes the count enable every pre_q+1 RUN cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pre_q   <= '0;
      r_pre_cnt <= '0;
    end else begin
      if (w_acc) begin
        r_pre_q <= io_bus.cfg_prescale;
      end
      if (w_start) begin
        r_pre_cnt <= '0;
      end else if (r_state == RUN) begin
        r_pre_cnt <= (r_pre_cnt == r_pre_q) ? '0 : r_pre_cnt + 1'b1;
      end
    end
  end

  assign w_en = (r_state == RUN) && (r_pre_cnt == r_pre_q);
`else
  assign w_en = 1'b1;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state plus counter control, tick and done; stop outranks a terminal event.
  always_comb begin
    w_state_nxt = r_state;
    w_clr       = 1'b0;
    w_cnt_en    = 1'b0;
    w_tick_nxt  = 1'b0;
    w_done_nxt  = r_done;
    case (r_state)
      IDLE, DONE: begin
        if (w_acc) begin
          w_done_nxt  = 1'b0;
          w_state_nxt = IDLE;
        end
        if (w_start) begin
          w_state_nxt = RUN;
          w_clr       = 1'b1;
          w_done_nxt  = 1'b0;
        end
      end
      RUN: begin
        if (io_bus.stop) begin
          w_state_nxt = IDLE;
          w_done_nxt  = 1'b0;
        end else if (w_term) begin
          w_tick_nxt = 1'b1;
          if (r_periodic) begin
            w_clr = 1'b1;
          end else begin
            w_done_nxt  = 1'b1;
            w_state_nxt = DONE;
          end
        end else if (w_en) begin
          w_cnt_en = 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Config latches and registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_limit    <= '0;
      r_periodic <= 1'b0;
      r_tick     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      if (w_acc) begin
        r_limit    <= io_bus.cfg_limit;
        r_periodic <= io_bus.cfg_periodic;
      end
      r_tick <= w_tick_nxt;
      r_done <= w_done_nxt;
    end
  end

  sync_counter_core #(.W(W)) u_core (
    .clk   (clk),
    .rst   (rst),
    .i_clr (w_clr),
    .i_en  (w_cnt_en),
    .o_cnt (w_cnt)
  );

  assign io_bus.cfg_ready = (r_state != RUN);
  assign io_bus.busy      = (r_state == RUN);
  assign io_bus.count     = w_cnt;
  assign io_bus.tick      = r_tick;
  assign io_bus.done      = r_done;

endmodule

// File: tb/tb_interval_timer_ctrl.sv
// Directed bench for interval_timer_ctrl with hand-computed expectations.
// Latency: inputs driven 1ns after posedge, outputs sampled at the same point.
// Backpressure: cfg_ready checked while running.
module tb_interval_timer_ctrl;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_ticks;

  always #5 clk = ~clk;

  interval_timer_ctrl_if #(.W(8)) tb_if ();

  interval_timer_ctrl #(.W(8)) dut (
    .clk    (clk),
    .rst    (rst),
    .io_bus (tb_if.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst                = 1'b1;
    tb_if.cfg_valid    = 1'b0;
    tb_if.cfg_limit    = '0;
    tb_if.cfg_periodic = 1'b0;
`ifdef INTERVAL_PRESCALE_EN
    tb_if.cfg_prescale = '0;
`endif
    tb_if.start        = 1'b0;
    tb_if.stop         = 1'b0;
    step();
    step();
    rst = 1'b0;
    step();
    chk("rst_count", tb_if.count, 0);
    chk("rst_busy", tb_if.busy, 0);
    chk("rst_tick", tb_if.tick, 0);
    chk("rst_done", tb_if.done, 0);
    chk("rst_cfg_ready", tb_if.cfg_ready, 1);

    // Reset mid-RUN: one-shot L=5, reset at count 3.
    tb_if.cfg_valid = 1'b1; tb_if.cfg_limit = 8'd5; tb_if.cfg_periodic = 1'b0; tb_if.start = 1'b1;
    step();
    tb_if.cfg_valid = 1'b0; tb_if.start = 1'b0;
    chk("t1_busy_run", tb_if.busy, 1);
    chk("t1_cfg_ready_run", tb_if.cfg_ready, 0);
    chk("t1_count0", tb_if.count, 0);
    repeat (3) step();
    chk("t1_count3", tb_if.count, 3);
    rst = 1'b1;
    #1;
    chk("t1_rst_count", tb_if.count, 0);
    chk("t1_rst_busy", tb_if.busy, 0);
    chk("t1_rst_tick", tb_if.tick, 0);
    chk("t1_rst_done", tb_if.done, 0);
    chk("t1_rst_cfg_ready", tb_if.cfg_ready, 1);
    #1;
    rst = 1'b0;

    // Limit register was reset to 0: start alone is ignored.
    tb_if.start = 1'b1;
    step();
    tb_if.start = 1'b0;
    chk("t4_zero_busy", tb_if.busy, 0);
    chk("t4_zero_tick", tb_if.tick, 0);

    // One-shot L=3.
    tb_if.cfg_valid = 1'b1; tb_if.cfg_limit = 8'd3; tb_if.cfg_periodic = 1'b0;
    step();
    tb_if.cfg_valid = 1'b0;
    chk("t2_cfg_idle", tb_if.busy, 0);
    tb_if.start = 1'b1;
    step();
    tb_if.start = 1'b0;
    chk("t2_count0", tb_if.count, 0);
    for (int k = 1; k <= 3; k++) begin
      step();
      chk("t2_count_k", tb_if.count, k);
      chk("t2_tick_low", tb_if.tick, 0);
    end
    step();
    chk("t2_tick", tb_if.tick, 1);
    chk("t2_done", tb_if.done, 1);
    chk("t2_busy_off", tb_if.busy, 0);
    chk("t2_count_hold", tb_if.count, 3);
    step();
    chk("t2_tick_drop", tb_if.tick, 0);
    chk("t2_done_sticky", tb_if.done, 1);
    chk("t2_count_hold2", tb_if.count, 3);
    chk("t2_cfg_ready_done", tb_if.cfg_ready, 1);

    // Config accepted in DONE clears done and returns to IDLE.
    tb_if.cfg_valid = 1'b1; tb_if.cfg_limit = 8'd2; tb_if.cfg_periodic = 1'b1;
    step();
    tb_if.cfg_valid = 1'b0;
    chk("t3_done_clr", tb_if.done, 0);
    chk("t3_idle", tb_if.busy, 0);

    // Periodic L=2 for 9 cycles.
    tb_if.start = 1'b1;
    step();
    tb_if.start = 1'b0;
    chk("t3_count0", tb_if.count, 0);
    n_ticks = 0;
    for (int k = 1; k <= 9; k++) begin
      step();
      chk("t3_count_seq", tb_if.count, k % 3);
      chk("t3_tick_seq", tb_if.tick, (k % 3 == 0) ? 1 : 0);
      if (tb_if.tick === 1'b1) n_ticks++;
    end
    chk("t3_tick_total", n_ticks, 3);
    chk("t3_still_run", tb_if.busy, 1);

    // cfg_valid ignored in RUN, then stop on the terminal edge.
    tb_if.cfg_valid = 1'b1; tb_if.cfg_limit = 8'd7;
    step();
    tb_if.cfg_valid = 1'b0;
    chk("t5_cfg_ready_run", tb_if.cfg_ready, 0);
    chk("t5_count1", tb_if.count, 1);
    step();
    chk("t5_count2", tb_if.count, 2);
    tb_if.stop = 1'b1;
    step();
    tb_if.stop = 1'b0;
    chk("t5_stop_busy", tb_if.busy, 0);
    chk("t5_stop_count", tb_if.count, 2);
    chk("t5_stop_tick", tb_if.tick, 0);
    chk("t5_stop_done", tb_if.done, 0);
    tb_if.start = 1'b1;
    step();
    tb_if.start = 1'b0;
    chk("t5_restart_count", tb_if.count, 0);
    repeat (3) step();
    chk("t5_limit_kept_count", tb_if.count, 0);
    chk("t5_limit_kept_tick", tb_if.tick, 1);
    tb_if.stop = 1'b1;
    step();
    chk("t5_stop2_busy", tb_if.busy, 0);
    tb_if.start = 1'b1;
    step();
    tb_if.start = 1'b0;
    chk("t5_start_wins", tb_if.busy, 1);
    step();
    tb_if.stop = 1'b0;
    chk("t5_stop_in_run", tb_if.busy, 0);

    // Config L=0 with start: ignored. Config L=4 with start: runs to 4.
    tb_if.cfg_valid = 1'b1; tb_if.cfg_limit = 8'd0; tb_if.cfg_periodic = 1'b0; tb_if.start = 1'b1;
    step();
    chk("t4_cfg0_busy", tb_if.busy, 0);
    tb_if.cfg_limit = 8'd4;
    step();
    tb_if.cfg_valid = 1'b0; tb_if.start = 1'b0;
    chk("t4_l4_busy", tb_if.busy, 1);
    chk("t4_l4_count0", tb_if.count, 0);
    repeat (4) step();
    chk("t4_l4_count4", tb_if.count, 4);
    chk("t4_l4_tick_pre", tb_if.tick, 0);
    step();
    chk("t4_l4_tick", tb_if.tick, 1);
    chk("t4_l4_done", tb_if.done, 1);
    chk("t4_l4_count_hold", tb_if.count, 4);

    // Full-scale limit 255: no wrap.
    tb_if.cfg_valid = 1'b1; tb_if.cfg_limit = 8'd255; tb_if.cfg_periodic = 1'b0; tb_if.start = 1'b1;
    step();
    tb_if.cfg_valid = 1'b0; tb_if.start = 1'b0;
    chk("max_done_clr", tb_if.done, 0);
    repeat (255) step();
    chk("max_count255", tb_if.count, 255);
    chk("max_busy", tb_if.busy, 1);
    step();
    chk("max_tick", tb_if.tick, 1);
    chk("max_done", tb_if.done, 1);
    chk("max_count_hold", tb_if.count, 255);

`ifdef INTERVAL_PRESCALE_EN
    // Prescale 2, L=1, one-shot: count moves every 3rd cycle, done after 6.
    tb_if.cfg_valid = 1'b1; tb_if.cfg_limit = 8'd1; tb_if.cfg_periodic = 1'b0;
    tb_if.cfg_prescale = 2; tb_if.start = 1'b1;
    step();
    tb_if.cfg_valid = 1'b0; tb_if.start = 1'b0;
    chk("t6_count0", tb_if.count, 0);
    for (int k = 1; k <= 6; k++) begin
      step();
      chk("t6_count_seq", tb_if.count, (k >= 3) ? 1 : 0);
      chk("t6_done_seq", tb_if.done, (k == 6) ? 1 : 0);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
